// File: rtl/dram_arbiter.sv
// Round-robin arbiter: shares one single-ported DRAM among NUM_REQ requesters, one transaction at a time.
// Latency: accept (IDLE) -> ISSUE -> WAIT (>=1 cycle) -> RESP; 4 cycles minimum with a 1-cycle DRAM.
// Backpressure: RESP holds resp_valid/resp_rdata until resp_ready[owner]; req_ready stays low outside IDLE.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   req_valid/req_ready              per-requester request handshake (req_ready at most one-hot)
//   req_write/req_addr/req_wdata     per-requester request payload, 64 bits per requester packed
//   resp_valid/resp_ready/resp_rdata one-hot response handshake back to the owning requester
//   mem_req_*/mem_resp_ready         DRAM request, single-cycle strobe in ISSUE
//   mem_resp_valid/mem_resp_rdata    DRAM response pulse, only honoured in WAIT
//   busy                             high whenever the FSM is not in IDLE
module dram_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [NUM_REQ*64-1:0]   req_addr,
  input  logic [NUM_REQ*64-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      resp_valid,
  input  logic [NUM_REQ-1:0]      resp_ready,
  output logic [63:0]             resp_rdata,
  output logic                    mem_req_valid,
  output logic                    mem_req_write,
  output logic [63:0]             mem_req_addr,
  output logic [63:0]             mem_req_wdata,
  output logic                    mem_resp_ready,
  input  logic                    mem_resp_valid,
  input  logic [63:0]             mem_resp_rdata,
  output logic                    busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W:0]   NREQ = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] rr_ptr;
  logic             lat_write;
  logic [63:0]      lat_addr;
  logic [63:0]      lat_wdata;
  logic [63:0]      lat_rdata;

  logic             found;
  logic [IDX_W-1:0] winner;
  logic [IDX_W:0]   idx;
  logic             sel_write;
  logic [63:0]      sel_addr;
  logic [63:0]      sel_wdata;

  // Search upward from rr_ptr with wrap; the first valid requester wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[IDX_W-1:0];
      end
    end
  end

  // Payload mux for the winner; constant slices per requester.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDX_W'(i)) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[64*i +: 64];
        sel_wdata = req_wdata[64*i +: 64];
      end
    end
  end

  // Grant is combinational; suppressed under reset because no accept happens on a reset edge.
  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && found) req_ready[winner] = 1'b1;
  end

  assign mem_req_write = lat_write;
  assign mem_req_addr  = lat_addr;
  assign mem_req_wdata = lat_wdata;
  assign resp_rdata    = lat_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      owner          <= '0;
      rr_ptr         <= '0;
      lat_write      <= 1'b0;
      lat_addr       <= '0;
      lat_wdata      <= '0;
      lat_rdata      <= '0;
      mem_req_valid  <= 1'b0;
      mem_resp_ready <= 1'b0;
      resp_valid     <= '0;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            owner          <= winner;
            rr_ptr         <= (winner == LAST) ? '0 : winner + IDX_W'(1);
            lat_write      <= sel_write;
            lat_addr       <= sel_addr;
            lat_wdata      <= sel_wdata;
            mem_req_valid  <= 1'b1;
            mem_resp_ready <= 1'b1;
            busy           <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          // Strobe lasts exactly one cycle.
          mem_req_valid  <= 1'b0;
          mem_resp_ready <= 1'b0;
          state          <= WAIT;
        end
        WAIT: begin
          if (mem_resp_valid) begin
            lat_rdata  <= mem_resp_rdata;
            resp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready[owner]) begin
            resp_valid <= '0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
module tb_dram_arbiter;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0, req_ready, req_write = '0;
  logic [N*64-1:0] req_addr = '0, req_wdata = '0;
  logic [N-1:0]    resp_valid, resp_ready = '1;
  logic [63:0]     resp_rdata, mem_req_addr, mem_req_wdata;
  logic            mem_req_valid, mem_req_write, mem_resp_ready, busy;
  logic            mem_resp_valid = 1'b0;
  logic [63:0]     mem_resp_rdata = '0;

  dram_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_ready(mem_resp_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int owner; logic [63:0] data; int acc_cyc; int lat; bit seen;} exp_t;
  typedef struct {logic write; logic [63:0] addr; logic [63:0] wdata;} iss_t;

  exp_t        exp_q[$];
  iss_t        iss_q[$];
  int          glog[$], gcyc[$];
  logic [63:0] ref_mem  [4096];
  logic [63:0] dram_mem [4096];
  int          ref_rr, checks, errors, cyc, resp_cnt, issue_cnt, stall_cycles, dram_lat, cd;
  bit          ref_busy, rand_rdy, force_pulse;
  bit [N-1:0]  hold, acc_flag;
  logic [63:0] pend, force_data, last_rdata;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Round-robin rule: first requesting index at or after the pointer, modulo N.
  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // Reference model + scoreboard: predicts grants, pushes expected responses, checks responses.
  always @(negedge clk) begin
    if (rst_n) begin
      int w;
      logic [N-1:0] er, oh;
      check_eq("busy", busy, ref_busy);
      er = '0;
      w  = -1;
      if (!ref_busy) begin
        w = pick(req_valid, ref_rr);
        if (w >= 0) er[w] = 1'b1;
      end
      check_eq("req_ready", req_ready, er);
      if (w >= 0) begin
        exp_t e;
        iss_t s;
        int   wd;
        wd = int'(req_addr[64*w+3 +: 12]);
        e.owner = w; e.data = ref_mem[wd]; e.acc_cyc = cyc; e.lat = 3 + dram_lat; e.seen = 0;
        if (req_write[w]) ref_mem[wd] = req_wdata[64*w +: 64];
        s.write = req_write[w]; s.addr = req_addr[64*w +: 64]; s.wdata = req_wdata[64*w +: 64];
        exp_q.push_back(e);
        iss_q.push_back(s);
        ref_rr   = (w + 1) % N;
        ref_busy = 1;
        acc_flag[w] = 1'b1;
        glog.push_back(w);
        gcyc.push_back(cyc);
      end
      if (resp_valid !== '0) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_resp", resp_valid, '0);
        end else begin
          oh = '0;
          oh[exp_q[0].owner] = 1'b1;
          check_eq("resp_valid", resp_valid, oh);
          check_eq("resp_rdata", resp_rdata, exp_q[0].data);
          if (!exp_q[0].seen) begin
            exp_q[0].seen = 1;
            check_eq("resp_latency", 64'(cyc - exp_q[0].acc_cyc), 64'(exp_q[0].lat));
          end
          if (resp_ready[exp_q[0].owner]) begin
            last_rdata = resp_rdata;
            void'(exp_q.pop_front());
            ref_busy = 0;
            resp_cnt++;
          end else begin
            stall_cycles++;
          end
        end
      end
      check_eq("mem_resp_ready", mem_resp_ready, mem_req_valid);
    end
  end

  // Behavioural DRAM: read-before-write on each strobe, response pulse 1+dram_lat cycles later.
  always @(negedge clk) begin
    if (mem_req_valid === 1'b1 && mem_resp_ready === 1'b1) begin
      int   wd;
      iss_t s;
      wd = int'(mem_req_addr[14:3]);
      issue_cnt++;
      pend = dram_mem[wd];
      if (mem_req_write) dram_mem[wd] = mem_req_wdata;
      cd = 1 + dram_lat;
      if (iss_q.size() == 0) begin
        check_eq("spurious_mem_req", mem_req_valid, 1'b0);
      end else begin
        s = iss_q.pop_front();
        check_eq("mem_req_write", mem_req_write, s.write);
        check_eq("mem_req_addr", mem_req_addr, s.addr);
        check_eq("mem_req_wdata", mem_req_wdata, s.wdata);
      end
    end
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    if (force_pulse) begin
      mem_resp_valid = 1'b1;
      mem_resp_rdata = force_data;
      force_pulse    = 0;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = pend;
      end
    end
  end

  // Requester side: drop an accepted request unless it is held; optional random resp_ready.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_flag[i]) begin
        acc_flag[i] = 1'b0;
        if (!hold[i]) req_valid[i] = 1'b0;
      end
    end
    if (rand_rdy) resp_ready = N'($urandom);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_req(input int i, input logic w, input logic [63:0] a, input logic [63:0] d);
    req_write[i]          = w;
    req_addr[64*i +: 64]  = a;
    req_wdata[64*i +: 64] = d;
    req_valid[i]          = 1'b1;
  endtask

  task automatic preload(input logic [63:0] a, input logic [63:0] d);
    ref_mem[int'(a[14:3])]  = d;
    dram_mem[int'(a[14:3])] = d;
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while ((req_valid != '0 || exp_q.size() != 0) && t < budget) begin
      tick(1);
      t++;
    end
    check_eq("drain_outstanding", 64'(exp_q.size()), 64'd0);
    check_eq("drain_requests", req_valid, '0);
  endtask

  task automatic reset_dut(input int n);
    req_valid = '0;
    hold      = '0;
    acc_flag  = '0;
    rst_n     = 1'b0;
    exp_q.delete();
    iss_q.delete();
    glog.delete();
    gcyc.delete();
    ref_busy = 0;
    ref_rr   = 0;
    tick(n);
    @(negedge clk);
    check_eq("rst_req_ready", req_ready, '0);
    check_eq("rst_resp_valid", resp_valid, '0);
    check_eq("rst_resp_rdata", resp_rdata, '0);
    check_eq("rst_mem_req_valid", mem_req_valid, 1'b0);
    check_eq("rst_mem_req_write", mem_req_write, 1'b0);
    check_eq("rst_mem_req_addr", mem_req_addr, '0);
    check_eq("rst_mem_req_wdata", mem_req_wdata, '0);
    check_eq("rst_mem_resp_ready", mem_resp_ready, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int base_iss, base_resp, t;
    int rr_exp[5];
    logic [63:0] a;
    rr_exp = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 4096; i++) begin
      ref_mem[i]  = '0;
      dram_mem[i] = '0;
    end
    dram_lat = 0;
    reset_dut(2);

    // Single read by requester 1.
    preload(64'h80, 64'hDEAD_BEEF);
    tick(1);
    base_iss = issue_cnt;
    set_req(1, 1'b0, 64'h80, 64'h0);
    wait_idle(50);
    check_eq("single_read_data", last_rdata, 64'hDEAD_BEEF);
    check_eq("single_read_strobes", 64'(issue_cnt - base_iss), 64'd1);
    check_eq("single_read_grant", 64'(glog[glog.size()-1]), 64'd1);

    // Write then read: write returns old contents.
    preload(64'h100, 64'h5555_0000_AAAA);
    set_req(0, 1'b1, 64'h100, 64'h1234);
    wait_idle(50);
    check_eq("write_old_data", last_rdata, 64'h5555_0000_AAAA);
    set_req(2, 1'b0, 64'h100, 64'h0);
    wait_idle(50);
    check_eq("read_after_write", last_rdata, 64'h1234);

    // Backpressure: response held for several cycles with no new DRAM strobes.
    resp_ready   = '0;
    stall_cycles = 0;
    set_req(3, 1'b0, 64'h80, 64'h0);
    t = 0;
    while (resp_valid == '0 && t < 20) begin
      tick(1);
      t++;
    end
    base_iss = issue_cnt;
    tick(5);
    check_eq("bp_stall_5", 64'(stall_cycles >= 5), 64'd1);
    check_eq("bp_no_strobe", 64'(issue_cnt - base_iss), 64'd0);
    resp_ready = '1;
    wait_idle(50);
    check_eq("bp_data", last_rdata, 64'hDEAD_BEEF);

    // Stray DRAM pulse while idle.
    base_resp   = resp_cnt;
    force_data  = 64'hFFFF;
    force_pulse = 1;
    tick(3);
    check_eq("stray_no_resp", 64'(resp_cnt - base_resp), 64'd0);
    preload(64'h200, 64'h0BAD_CAFE);
    set_req(1, 1'b0, 64'h200, 64'h0);
    wait_idle(50);
    check_eq("stray_next_read", last_rdata, 64'h0BAD_CAFE);

    // Round-robin with all requesters held high from reset.
    rst_n = 1'b0;
    reset_dut(2);
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 64'h80, 64'h0);
    hold = '1;
    t = 0;
    while (glog.size() < 5 && t < 200) begin
      tick(1);
      t++;
    end
    hold      = '0;
    req_valid = '0;
    wait_idle(50);
    check_eq("rr_grant_count", 64'(glog.size() >= 5), 64'd1);
    for (int i = 0; i < 5 && i < glog.size(); i++) begin
      check_eq($sformatf("rr_grant_%0d", i), 64'(glog[i]), 64'(rr_exp[i]));
      if (i > 0) check_eq($sformatf("rr_gap_%0d", i), 64'(gcyc[i] - gcyc[i-1]), 64'd4);
    end

    // Reset while in WAIT; the DRAM pulse lands after reset in IDLE.
    dram_lat = 3;
    base_iss = issue_cnt;
    set_req(2, 1'b0, 64'h80, 64'h0);
    t = 0;
    while (issue_cnt == base_iss && t < 20) begin
      tick(1);
      t++;
    end
    base_resp = resp_cnt;
    reset_dut(1);
    tick(4);
    check_eq("mid_rst_no_resp", 64'(resp_cnt - base_resp), 64'd0);
    dram_lat = 0;
    set_req(0, 1'b0, 64'h100, 64'h0);
    set_req(3, 1'b0, 64'h200, 64'h0);
    wait_idle(50);
    check_eq("mid_rst_rr_ptr", 64'(glog[0]), 64'd0);
    check_eq("mid_rst_second", 64'(glog[1]), 64'd3);

    // Randomized traffic phases.
    for (int p = 0; p < 4; p++) begin
      dram_lat = $urandom_range(0, 3);
      rand_rdy = p[0];
      repeat (250) begin
        tick(1);
        for (int i = 0; i < N; i++) begin
          if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
            a = {$urandom, $urandom};
            a[14:3] = 12'($urandom_range(0, 15));
            set_req(i, 1'($urandom_range(0, 1)), a, {$urandom, $urandom});
          end
        end
      end
      wait_idle(600);
      rand_rdy   = 0;
      resp_ready = '1;
      tick(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
